// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter : shares one external memory port between the I-cache
//                    refill and D-cache refill/writeback as fixed-length bursts.
// Optional: MEMARB_ROUND_ROBIN_EN (alternate grants under contention)
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              i_I_req,
    input  logic [ADDR_W-1:0] i_I_addr,
    output logic [DATA_W-1:0] o_I_rdata,
    output logic              o_I_rvalid,
    output logic              o_I_done,
    input  logic              i_D_req,
    input  logic              i_D_we,
    input  logic [ADDR_W-1:0] i_D_addr,
    input  logic [DATA_W-1:0] i_D_wdata,
    output logic              o_D_wack,
    output logic [DATA_W-1:0] o_D_rdata,
    output logic              o_D_rvalid,
    output logic              o_D_done,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_ack
);

    localparam int BYTES   = DATA_W / 8;
    localparam int BYTE_SH = $clog2(BYTES);
    localparam int LINE_SH = $clog2(LINE_WORDS * BYTES);
    localparam int CNT_W   = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(LINE_WORDS - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << LINE_SH) - ADDR_W'(1));

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               win_d_q, win_d_d;     // 1 = D side owns the burst
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [CNT_W-1:0]   beat_q, beat_d;
    logic               last_d_q, last_d_d;   // last-served side, 1 = D
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               i_rvalid_q, i_rvalid_d;
    logic               d_rvalid_q, d_rvalid_d;
    logic               pick_d;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q    <= ST_IDLE;
            win_d_q    <= 1'b0;
            we_q       <= 1'b0;
            base_q     <= '0;
            beat_q     <= '0;
            last_d_q   <= 1'b0;
            rdata_q    <= '0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_d_q    <= win_d_d;
            we_q       <= we_d;
            base_q     <= base_d;
            beat_q     <= beat_d;
            last_d_q   <= last_d_d;
            rdata_q    <= rdata_d;
            i_rvalid_q <= i_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        win_d_d    = win_d_q;
        we_d       = we_q;
        base_d     = base_q;
        beat_d     = beat_q;
        last_d_d   = last_d_q;
        rdata_d    = rdata_q;
        i_rvalid_d = 1'b0;
        d_rvalid_d = 1'b0;
        pick_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_I_req || i_D_req) begin
`ifdef MEMARB_ROUND_ROBIN_EN
                    if (i_I_req && i_D_req)
                        pick_d = ~last_d_q;
                    else
                        pick_d = i_D_req;
`else
                    pick_d = i_D_req;
`endif
                    win_d_d = pick_d;
                    we_d    = pick_d & i_D_we;
                    base_d  = (pick_d ? i_D_addr : i_I_addr) & LINE_MASK;
                    beat_d  = '0;
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                if (i_mem_ack) begin
                    if (!we_q) begin
                        rdata_d = i_mem_rdata;
                        if (win_d_q)
                            d_rvalid_d = 1'b1;
                        else
                            i_rvalid_d = 1'b1;
                    end
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = ST_DONE;
                    end else begin
                        beat_d = beat_q + CNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                last_d_d = win_d_q;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decode from registered state so an async reset clears them at once.
    logic w_burst, w_done;
    assign w_burst = (state_q == ST_BURST);
    assign w_done  = (state_q == ST_DONE);

    assign o_mem_req   = w_burst;
    assign o_mem_we    = w_burst & we_q;
    assign o_mem_addr  = w_burst ? (base_q | (ADDR_W'(beat_q) << BYTE_SH)) : '0;
    assign o_mem_wdata = (w_burst && we_q) ? i_D_wdata : '0;
    assign o_D_wack    = w_burst & we_q & i_mem_ack;

    assign o_I_rvalid  = i_rvalid_q;
    assign o_I_rdata   = i_rvalid_q ? rdata_q : '0;
    assign o_I_done    = w_done & ~win_d_q;
    assign o_D_rvalid  = d_rvalid_q;
    assign o_D_rdata   = d_rvalid_q ? rdata_q : '0;
    assign o_D_done    = w_done & win_d_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter : directed self-checking bench for mem_port_arbiter
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 4;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          i_I_req;
    logic [AW-1:0] i_I_addr;
    logic [DW-1:0] o_I_rdata;
    logic          o_I_rvalid;
    logic          o_I_done;
    logic          i_D_req;
    logic          i_D_we;
    logic [AW-1:0] i_D_addr;
    logic [DW-1:0] i_D_wdata;
    logic          o_D_wack;
    logic [DW-1:0] o_D_rdata;
    logic          o_D_rvalid;
    logic          o_D_done;
    logic          o_mem_req;
    logic          o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_wdata;
    logic [DW-1:0] i_mem_rdata;
    logic          i_mem_ack;

    int n_cmp = 0;
    int n_err = 0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(LW)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .i_I_req    (i_I_req),
        .i_I_addr   (i_I_addr),
        .o_I_rdata  (o_I_rdata),
        .o_I_rvalid (o_I_rvalid),
        .o_I_done   (o_I_done),
        .i_D_req    (i_D_req),
        .i_D_we     (i_D_we),
        .i_D_addr   (i_D_addr),
        .i_D_wdata  (i_D_wdata),
        .o_D_wack   (o_D_wack),
        .o_D_rdata  (o_D_rdata),
        .o_D_rvalid (o_D_rvalid),
        .o_D_done   (o_D_done),
        .o_mem_req  (o_mem_req),
        .o_mem_we   (o_mem_we),
        .o_mem_addr (o_mem_addr),
        .o_mem_wdata(o_mem_wdata),
        .i_mem_rdata(i_mem_rdata),
        .i_mem_ack  (i_mem_ack)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 2-3 ns after each rising edge.
    task automatic tick;
        @(posedge Clk);
        #2;
    endtask

    function automatic logic [159:0] all_outs();
        return {o_I_rdata, o_I_rvalid, o_I_done, o_D_wack, o_D_rdata, o_D_rvalid,
                o_D_done, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata};
    endfunction

    // Entered on the first BURST cycle; ack every cycle; returns on the IDLE cycle.
    task automatic run_read(input bit is_d, input logic [31:0] base,
                            input logic [31:0] seed, input int drop_at);
        for (int b = 0; b < LW; b++) begin
            i_mem_ack   = 1'b1;
            i_mem_rdata = seed + 32'(b);
            if (b == drop_at) begin
                if (is_d) i_D_req = 1'b0;
                else      i_I_req = 1'b0;
            end
            #1;
            chk("rd_req_we", {o_mem_req, o_mem_we}, 2'b10);
            chk("rd_addr", o_mem_addr, base + 32'(4 * b));
            if (is_d) begin
                chk("rd_d_rvalid", o_D_rvalid, (b > 0));
                if (b > 0) chk("rd_d_rdata", o_D_rdata, seed + 32'(b - 1));
                chk("rd_i_quiet", {o_I_rvalid, o_I_done, o_I_rdata}, '0);
            end else begin
                chk("rd_i_rvalid", o_I_rvalid, (b > 0));
                if (b > 0) chk("rd_i_rdata", o_I_rdata, seed + 32'(b - 1));
                chk("rd_d_quiet", {o_D_rvalid, o_D_done, o_D_rdata, o_D_wack}, '0);
            end
            tick;
        end
        i_mem_ack = 1'b0;
        if (is_d) i_D_req = 1'b0;
        else      i_I_req = 1'b0;
        #1;
        if (is_d)
            chk("rd_d_done", {o_D_done, o_D_rvalid, o_D_rdata, o_I_done, o_I_rvalid, o_mem_req},
                {1'b1, 1'b1, 32'(seed + 32'd3), 1'b0, 1'b0, 1'b0});
        else
            chk("rd_i_done", {o_I_done, o_I_rvalid, o_I_rdata, o_D_done, o_D_rvalid, o_mem_req},
                {1'b1, 1'b1, 32'(seed + 32'd3), 1'b0, 1'b0, 1'b0});
        tick;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  beats;
        logic ack_now;

        Rst         = 1'b0;
        i_I_req     = 1'b1;
        i_I_addr    = 32'h0000_0106;
        i_D_req     = 1'b1;
        i_D_we      = 1'b1;
        i_D_addr    = 32'h0000_3008;
        i_D_wdata   = 32'h5A5A_5A5A;
        i_mem_rdata = 32'hDEAD_BEEF;
        i_mem_ack   = 1'b0;

        // Held in reset with both requests high and ack toggling.
        for (int k = 0; k < 4; k++) begin
            tick;
            i_mem_ack = ~i_mem_ack;
            #1;
            chk("reset_outs", all_outs(), '0);
        end

        // Release: requests seen at the next edge, grant one cycle later; D wins.
        i_D_we    = 1'b0;
        i_mem_ack = 1'b0;
        Rst       = 1'b1;
        #1;
        chk("release_req_low", o_mem_req, 1'b0);
        tick;
        run_read(1'b1, 32'h0000_3000, 32'hD000_0000, LW);
        #1;
        chk("turnaround_idle", {o_mem_req, o_I_done, o_D_done}, 3'b000);
        tick;
        // I refill of the line holding 0x106.
        run_read(1'b0, 32'h0000_0100, 32'h1111_0000, LW);

        // D writeback with ack on burst cycles 1,4,5,9.
        i_D_req  = 1'b1;
        i_D_we   = 1'b1;
        i_D_addr = 32'h0000_2000;
        tick;
        beats = 0;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            ack_now   = (cyc == 1) || (cyc == 4) || (cyc == 5) || (cyc == 9);
            i_mem_ack = ack_now;
            i_D_wdata = 32'hA500_0000 + 32'(cyc);
            #1;
            chk("wb_wdata", o_mem_wdata, 32'hA500_0000 + 32'(cyc));
            chk("wb_wack", o_D_wack, ack_now);
            chk("wb_addr", o_mem_addr, 32'h0000_2000 + 32'(4 * beats));
            chk("wb_ctl", {o_mem_req, o_mem_we, o_D_done, o_D_rvalid}, 4'b1100);
            tick;
            if (ack_now) beats++;
        end
        i_mem_ack = 1'b0;
        i_D_req   = 1'b0;
        #1;
        chk("wb_done", {o_D_done, o_D_rvalid, o_mem_req, o_I_done, o_D_wack}, 5'b10000);
        tick;
        i_D_we = 1'b0;

        // I request dropped after beat 1: burst still completes.
        i_I_addr = 32'h0000_004C;
        i_I_req  = 1'b1;
        tick;
        run_read(1'b0, 32'h0000_0040, 32'h4400_0000, 2);

        // Reset asserted at beat 2 of a D refill.
        i_D_req  = 1'b1;
        i_D_addr = 32'h0000_5004;
        tick;
        for (int b = 0; b < 2; b++) begin
            i_mem_ack   = 1'b1;
            i_mem_rdata = 32'h5500_0000 + 32'(b);
            tick;
        end
        #1;
        chk("mid_addr", {o_mem_req, o_mem_addr}, {1'b1, 32'h0000_5008});
        Rst = 1'b0;
        #1;
        chk("rst_async_outs", all_outs(), '0);
        i_D_req = 1'b0;
        tick;
        tick;
        Rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            i_mem_ack = 1'b1;
            #1;
            chk("post_rst_quiet", {o_D_done, o_I_done, o_mem_req, o_D_rvalid, o_I_rvalid}, 5'b00000);
            tick;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
